// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; optional signed mode via SEQ_DIVIDER_SIGNED_EN.
// Latency: WIDTH cycles from accepted load to done (WIDTH+1 when signed); divide-by-zero is 1 cycle.
// Backpressure: none; load is ignored while busy, and results are held until the next accepted load.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q, neg_r;
`endif

  // Operand magnitudes fed to the unsigned core.
`ifdef SEQ_DIVIDER_SIGNED_EN
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // One restoring step: shift {R,Q} left, trial-subtract at WIDTH+1 bits, keep R if negative.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: accept loads only when idle or done; leave RUN after WIDTH steps.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (load) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        last_step = (cnt == CW'(1));
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (last_step) state_nxt = FIX;
`else
        if (last_step) state_nxt = DONE;
`endif
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIX: state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      if (divisor == '0) begin
        // No iteration: report the saturated quotient and pass the dividend through.
        div_by_zero <= 1'b1;
        quotient    <= '1;
        remainder   <= dividend;
        cnt         <= '0;
      end else begin
        div_by_zero <= 1'b0;
        rem_q       <= '0;
        quo_q       <= dvd_mag;
        dvsr_q      <= dvs_mag;
        cnt         <= CW'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r       <= dividend[WIDTH-1];
`endif
      end
    end else if (state == RUN) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt - CW'(1);
`ifndef SEQ_DIVIDER_SIGNED_EN
      if (last_step) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
      end
`endif
    end
`ifdef SEQ_DIVIDER_SIGNED_EN
    else if (state == FIX) begin
      // Truncate toward zero; remainder follows the dividend's sign.
      quotient  <= neg_q ? -quo_q : quo_q;
      remainder <= neg_r ? -rem_q : rem_q;
    end
`endif
  end

  // Status flags decode straight from the state register.
`ifdef SEQ_DIVIDER_SIGNED_EN
  assign busy = (state == RUN) || (state == FIX);
`else
  assign busy = (state == RUN);
`endif
  assign done = (state == DONE);

endmodule
